// File: rtl/vmem_arbiter.sv
// ---------------------------------------------------------------------------
// vmem_arbiter
//
// Drives the 4-state pixel sequencer and shares the single-port synchronous
// video RAM between the pixel generator (PG) and the CPU.
//
// PG slots:  pixel_state 0 (TEXT_FETCH) and 1 (GLYPH_FETCH) while enabled and
//            the display is active. In these cycles the RAM address is pg_addr
//            and nothing is written.
// CPU slots: pixel_state 2 while enabled, or any state while enable is low.
//            Build option VMEM_BLANK_GRANT_EN also makes every state a CPU
//            slot while enabled and display_active is low (blanking).
//
// CPU handshake (req/ack): cpu_req is a level. cpu_we, cpu_addr and cpu_wdata
// must stay stable from the rise of cpu_req until the cycle cpu_ack is high.
// A grant (cycle G) drives the RAM directly from the CPU inputs; G+1 waits
// for the synchronous RAM; G+2 pulses cpu_ack for one cycle with read data on
// cpu_rdata. cpu_req is ignored during the ack cycle, so a request still high
// at G+3 is a new access. Only one access is ever in flight.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   enable              display enable; low holds pixel_state at 0
//   display_active      high inside the visible region
//   pixel_state         sequencer state for the pixel generator
//   pg_addr / pg_data   PG read address in, RAM read data out (pure wire)
//   cpu_req/we/addr/wdata, cpu_ack/rdata   CPU access port
//   mem_addr/we/wdata/rdata                video RAM port
//   o_dbg_acc_state     CPU access FSM state (0 idle, 1 wait, 2 ack)
// ---------------------------------------------------------------------------
module vmem_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              display_active,
    output logic [1:0]        pixel_state,
    input  logic [ADDR_W-1:0] pg_addr,
    output logic [DATA_W-1:0] pg_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        o_dbg_acc_state
);

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,  // no access in flight, may grant
        ACC_WAIT = 2'd1,  // G+1: RAM read data arriving
        ACC_ACK  = 2'd2   // G+2: ack pulse, request ignored
    } acc_state_t;

    localparam logic [1:0] PS_SET_FG = 2'd2;

    logic [1:0]        r_pixel_state;
    acc_state_t        r_acc_state;
    acc_state_t        w_acc_next;
    logic              r_is_read;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              w_cpu_slot;
    logic              w_grant;

    // CPU slot decode. The PG slot is simply the complement while enabled
    // and active, so no separate PG decode is needed for the RAM mux.
`ifdef VMEM_BLANK_GRANT_EN
    assign w_cpu_slot = !enable || !display_active || (r_pixel_state == PS_SET_FG);
`else
    assign w_cpu_slot = !enable || (r_pixel_state == PS_SET_FG);
`endif

    assign w_grant = cpu_req && (r_acc_state == ACC_IDLE) && w_cpu_slot;

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pixel_state <= 2'd0;
            r_acc_state   <= ACC_IDLE;
            r_is_read     <= 1'b0;
            r_cpu_rdata   <= '0;
        end else begin
            // Disabling resets the sequencer on the next edge, abandoning
            // any PG fetch in progress.
            r_pixel_state <= enable ? (r_pixel_state + 2'd1) : 2'd0;
            r_acc_state   <= w_acc_next;
            if (w_grant) begin
                r_is_read <= !cpu_we;
            end
            // The RAM returns data in G+1; capture it for reads only so a
            // write leaves the previous read value on cpu_rdata.
            if ((r_acc_state == ACC_WAIT) && r_is_read) begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    // Next-state and RAM port mux
    always_comb begin
        w_acc_next = r_acc_state;
        mem_addr   = pg_addr;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        case (r_acc_state)
            ACC_IDLE: if (w_grant) w_acc_next = ACC_WAIT;
            ACC_WAIT: w_acc_next = ACC_ACK;
            ACC_ACK:  w_acc_next = ACC_IDLE;
            default:  w_acc_next = ACC_IDLE;
        endcase

        // A write commits at the edge closing cycle G.
        if (w_grant) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end
    end

    assign pixel_state     = r_pixel_state;
    assign pg_data         = mem_rdata;
    assign cpu_ack         = (r_acc_state == ACC_ACK);
    assign cpu_rdata       = r_cpu_rdata;
    assign o_dbg_acc_state = r_acc_state;

endmodule

// File: tb/tb_vmem_arbiter.sv
module tb_vmem_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;
`ifdef VMEM_BLANK_GRANT_EN
  localparam int BLANK_GAP = 3;
  localparam logic BLANK_CHK_PS = 1'b0;
`else
  localparam int BLANK_GAP = 4;
  localparam logic BLANK_CHK_PS = 1'b1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset;
  logic          enable;
  logic          display_active;
  logic [1:0]    pixel_state;
  logic [AW-1:0] pg_addr;
  logic [DW-1:0] pg_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_acc_state;

  vmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .display_active(display_active),
    .pixel_state(pixel_state), .pg_addr(pg_addr), .pg_data(pg_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .o_dbg_acc_state(dbg_acc_state)
  );

  // PG address is a function of pixel_state
  localparam logic [AW-1:0] PG_A0 = 15'h0042;
  localparam logic [AW-1:0] PG_A1 = 15'h2104;
  always_comb begin
    if (pixel_state == 2'd0)      pg_addr = PG_A0;
    else if (pixel_state == 2'd1) pg_addr = PG_A1;
    else                          pg_addr = 15'h0010;
  end

  // Synchronous single-port RAM model
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  // {check_state, expected pixel_state at ack, expected cpu_rdata}
  logic [DW+2:0] exp_q[$];
  logic [DW+2:0] mon_item;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && cpu_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_ack: got ack with no access outstanding, required none (cycle %0d)", cyc);
      end else begin
        mon_item = exp_q.pop_front();
        check("ack_rdata", cpu_rdata, mon_item[DW-1:0]);
        if (mon_item[DW+2]) check("ack_state", pixel_state, mon_item[DW+1:DW]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  int req_cyc;
  int lat;
  int ack_cyc [3];
  logic [AW-1:0] blk_a [3];
  logic [DW-1:0] blk_d [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic chk_ps, input logic [1:0] exp_ps, input logic [DW-1:0] exp_rd);
    exp_q.push_back({chk_ps, exp_ps, exp_rd});
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    req_cyc   = cyc;
  endtask

  task automatic wait_ack(input bit drop, output int latency);
    bit seen;
    seen = 1'b0;
    latency = -1;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      if (cpu_ack === 1'b1) begin
        seen = 1'b1;
        latency = cyc - req_cyc;
      end
    end
    check("ack_seen", seen, 1);
    if (drop || !seen) begin
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
    end
  endtask

  task automatic wait_ps(input logic [1:0] v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 8 && !hit; i++) begin
      tick();
      if (pixel_state == v) hit = 1'b1;
    end
    check("wait_state", hit, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; enable = 1'b0; display_active = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    blk_a[0] = 15'h0042; blk_d[0] = 16'h1111;
    blk_a[1] = 15'h2104; blk_d[1] = 16'h2222;
    blk_a[2] = 15'h2005; blk_d[2] = 16'hBEEF;
    repeat (3) tick();

    // Reset values
    check("rst_state", pixel_state, 0);
    check("rst_ack", cpu_ack, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_acc", dbg_acc_state, 0);
    reset = 1'b1;
    tick();

    // Preload while disabled: every state is a CPU slot, 2-cycle latency
    start_req(1'b1, 15'h0042, 16'h1111, 1'b1, 2'd0, 16'h0000);
    wait_ack(1'b1, lat);
    check("dis_wr0_lat", lat, 2);
    tick();
    start_req(1'b1, 15'h2104, 16'h2222, 1'b1, 2'd0, 16'h0000);
    wait_ack(1'b1, lat);
    check("dis_wr1_lat", lat, 2);
    tick();
    check("dis_state_hold", pixel_state, 0);

    // Sequencer 0,1,2,3,0
    enable = 1'b1; display_active = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq_state", pixel_state, i % 4);
    end

    // Active write requested in state 0
    start_req(1'b1, 15'h2005, 16'hBEEF, 1'b1, 2'd0, 16'h0000);
    #1;
    check("wr_s0_we", mem_we, 0);
    check("wr_s0_addr", mem_addr, 15'h0042);
    tick();
    check("wr_s1_we", mem_we, 0);
    check("wr_s1_addr", mem_addr, 15'h2104);
    tick();
    check("wr_s2_we", mem_we, 1);
    check("wr_s2_addr", mem_addr, 15'h2005);
    check("wr_s2_wdata", mem_wdata, 16'hBEEF);
    wait_ack(1'b1, lat);
    check("wr_lat", lat, 4);

    // Following read returns the written word
    start_req(1'b0, 15'h2005, 16'h0000, 1'b1, 2'd0, 16'hBEEF);
    wait_ack(1'b1, lat);
    check("rd_lat", lat, 4);

    // PG coexistence with a pending CPU read
    wait_ps(2'd0);
    start_req(1'b0, 15'h2104, 16'h0000, 1'b1, 2'd0, 16'h2222);
    #1;
    check("pg_s0_we", mem_we, 0);
    check("pg_s0_addr", mem_addr, 15'h0042);
    tick();
    check("pg_s1_we", mem_we, 0);
    check("pg_s1_addr", mem_addr, 15'h2104);
    check("pg_s1_acc", dbg_acc_state, 0);
    check("pg_s1_data", pg_data, 16'h1111);
    tick();
    check("pg_s2_data", pg_data, 16'h2222);
    wait_ack(1'b1, lat);
    check("pg_rd_lat", lat, 4);

    // Blanking throughput with request held high for three reads
    display_active = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      start_req(1'b0, blk_a[k], 16'h0000, BLANK_CHK_PS, 2'd0, blk_d[k]);
      wait_ack(k == 2, lat);
      ack_cyc[k] = cyc;
    end
    check("blank_gap1", ack_cyc[1] - ack_cyc[0], BLANK_GAP);
    check("blank_gap2", ack_cyc[2] - ack_cyc[1], BLANK_GAP);

    // Reset at G+1 of a read aborts it
    display_active = 1'b1;
    wait_ps(2'd2);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h2104;
    tick();
    check("rsta_inflight", dbg_acc_state, 1);
    reset = 1'b0;
    #1;
    check("rsta_state", pixel_state, 0);
    check("rsta_ack", cpu_ack, 0);
    check("rsta_rdata", cpu_rdata, 0);
    check("rsta_mem_we", mem_we, 0);
    cpu_req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("rsta_acc_after", dbg_acc_state, 0);
    check("rsta_no_ack", cpu_ack, 0);

    // Drop enable during a state-2 grant
    wait_ps(2'd2);
    start_req(1'b0, 15'h0042, 16'h0000, 1'b1, 2'd0, 16'h1111);
    enable = 1'b0;
    tick();
    check("dis_state0", pixel_state, 0);
    check("dis_inflight", dbg_acc_state, 1);
    wait_ack(1'b1, lat);
    check("dis_lat", lat, 2);
    tick();
    start_req(1'b0, 15'h2104, 16'h0000, 1'b1, 2'd0, 16'h2222);
    wait_ack(1'b1, lat);
    check("dis_rd2_lat", lat, 2);
    tick();

    // Top of address space is reachable
    start_req(1'b1, 15'h7FFF, 16'hA5A5, 1'b1, 2'd0, 16'h2222);
    wait_ack(1'b1, lat);
    check("top_wr_lat", lat, 2);
    tick();
    start_req(1'b0, 15'h7FFF, 16'h0000, 1'b1, 2'd0, 16'hA5A5);
    wait_ack(1'b1, lat);
    check("top_rd_lat", lat, 2);

    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
